// File: rtl/exec_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exec_mem_stage_pkg
//  Description : Shared definitions for the execute/memory stage and the CU:
//                default datapath widths and ALU opcode encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package exec_mem_stage_pkg;

    // Default widths shared with the control unit
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_BITS  = 5;

    // ALU function codes
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_PASS = 4'd9;
    localparam logic [3:0] OP_IDLE = 4'b1111;

endpackage : exec_mem_stage_pkg
`default_nettype wire

// File: rtl/exec_mem_stage_alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Purely combinational ALU. Produces the function result and
//                the carry/borrow bit; registering is done by the parent.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import exec_mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    input  logic [3:0]            opcode,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry
);

    logic [DATA_WIDTH:0] w_sum;
    logic [DATA_WIDTH:0] w_diff;
    logic [2:0]          w_shamt;

    // Extended add/subtract so the top bit carries the carry or borrow
    assign w_sum   = {1'b0, op1} + {1'b0, op2};
    assign w_diff  = {1'b0, op1} - {1'b0, op2};
    assign w_shamt = op2[2:0];

    // Function select; codes 10-14 and idle produce zero with carry cleared
    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (opcode)
            OP_ADD: begin
                result = w_sum[DATA_WIDTH-1:0];
                carry  = w_sum[DATA_WIDTH];
            end
            OP_SUB: begin
                result = w_diff[DATA_WIDTH-1:0];
                carry  = w_diff[DATA_WIDTH];
            end
            OP_AND:  result = op1 & op2;
            OP_OR:   result = op1 | op2;
            OP_XOR:  result = op1 ^ op2;
            OP_NOT:  result = ~op1;
            OP_SHL:  result = op1 << w_shamt;
            OP_SHR:  result = op1 >> w_shamt;
            OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, (op1 < op2)};
            OP_PASS: result = op1;
            default: result = '0;
        endcase
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/exec_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : exec_mem_stage
//  Description : Execute/memory datapath behind the control unit. Registered
//                ALU with flags, address adder, and a small data memory with
//                synchronous read-before-write behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_mem_stage
    import exec_mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int MEM_DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    input  logic [DATA_WIDTH-1:0] offset,
    input  logic [3:0]            opcode,
    input  logic                  sel1,
    input  logic                  sel3,
    input  logic                  w_r,
    output logic [DATA_WIDTH-1:0] result2,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic [ADDR_BITS-1:0]  mem_addr
);

    logic [DATA_WIDTH-1:0] w_ea_full;
    logic [DATA_WIDTH-1:0] w_alu_result;
    logic                  w_alu_carry;

    logic [DATA_WIDTH-1:0] r_alu;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_zero;
    logic                  r_carry;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Effective address wraps modulo the memory depth
    assign w_ea_full = sel3 ? (operand1 + offset) : operand1;
    assign mem_addr  = ADDR_BITS'(w_ea_full % MEM_DEPTH);

    alu_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu_core (
        .op1    (operand1),
        .op2    (operand2),
        .opcode (opcode),
        .result (w_alu_result),
        .carry  (w_alu_carry)
    );

    // ALU result and flags capture; idle opcode holds all three
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu   <= '0;
            r_zero  <= 1'b1;
            r_carry <= 1'b0;
        end else if (opcode != OP_IDLE) begin
            r_alu   <= w_alu_result;
            r_zero  <= (w_alu_result == '0);
            r_carry <= w_alu_carry;
        end
    end

    // Data memory array; reset preloads each word with its own index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= DATA_WIDTH'(i);
            end
        end else if (w_r) begin
            r_mem[mem_addr] <= operand2;
        end
    end

    // Synchronous read every edge; sees the pre-write contents on a collision
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[mem_addr];
        end
    end

    // Write-back mux draws only on registered values
    assign result2    = sel1 ? r_alu : r_rdata;
    assign zero_flag  = r_zero;
    assign carry_flag = r_carry;

endmodule : exec_mem_stage
`default_nettype wire

// File: tb/tb_exec_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exec_mem_stage
//  Description : Self-checking bench for exec_mem_stage with a behavioural
//                reference model (integer arithmetic, array memory).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_mem_stage;

    logic       clk;
    logic       rst_n;
    logic [7:0] operand1;
    logic [7:0] operand2;
    logic [7:0] offset;
    logic [3:0] opcode;
    logic       sel1;
    logic       sel3;
    logic       w_r;
    logic [7:0] result2;
    logic       zero_flag;
    logic       carry_flag;
    logic [4:0] mem_addr;

    int n_tests;
    int n_fail;

    // Reference model state
    int m_mem [32];
    int m_alu;
    int m_rdata;
    int m_zero;
    int m_carry;

    exec_mem_stage dut (
        .clk        (clk),
        .rst        (rst_n),
        .operand1   (operand1),
        .operand2   (operand2),
        .offset     (offset),
        .opcode     (opcode),
        .sel1       (sel1),
        .sel3       (sel3),
        .w_r        (w_r),
        .result2    (result2),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .mem_addr   (mem_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = i;
        m_alu   = 0;
        m_rdata = 0;
        m_zero  = 1;
        m_carry = 0;
    endfunction

    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int r, output int c);
        int s;
        c = 0;
        case (op)
            0: begin s = a + b; r = s % 256; c = s / 256; end
            1: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: r = (a * (1 << (b % 8))) % 256;
            7: r = a / (1 << (b % 8));
            8: r = (a < b) ? 1 : 0;
            9: r = a;
            default: r = 0;
        endcase
    endfunction

    function automatic int model_ea();
        if (sel3) return (int'(operand1) + int'(offset)) % 32;
        return int'(operand1) % 32;
    endfunction

    function automatic logic [7:0] model_r2();
        return sel1 ? 8'(m_alu) : 8'(m_rdata);
    endfunction

    // Advance one clock edge, updating the model with the pre-edge inputs
    task automatic tick();
        int ea, nr, r, c;
        ea = model_ea();
        nr = m_mem[ea];
        if (opcode != 4'hF) begin
            ref_alu(int'(opcode), int'(operand1), int'(operand2), r, c);
            m_alu   = r;
            m_carry = c;
            m_zero  = (r == 0) ? 1 : 0;
        end
        if (w_r) m_mem[ea] = int'(operand2);
        m_rdata = nr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; operand1 = 0; operand2 = 0; offset = 0;
        opcode = 4'hF; sel1 = 1'b0; sel3 = 1'b0; w_r = 1'b0;
        model_reset();
        #12;
        n_tests++;
        if (result2 !== 8'h00) begin
            n_fail++; $display("FAIL reset_result2_sel0 actual=%h expected=00", result2);
        end
        sel1 = 1'b1; #1;
        n_tests++;
        if (result2 !== 8'h00) begin
            n_fail++; $display("FAIL reset_result2_sel1 actual=%h expected=00", result2);
        end
        n_tests++;
        if (zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags actual z=%b c=%b expected z=1 c=0", zero_flag, carry_flag);
        end
        sel1 = 1'b0;
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_init_read();
        for (int a = 0; a < 32; a++) begin
            operand1 = 8'(a); sel3 = 1'b0; sel1 = 1'b0; opcode = 4'hF;
            tick();
            n_tests++;
            if (result2 !== 8'(a) || zero_flag !== 1'b1) begin
                n_fail++;
                $display("FAIL init_read addr=%0d actual=%h z=%b expected=%h z=1", a, result2, zero_flag, 8'(a));
            end
        end
    endtask

    task automatic test_add_sub();
        operand1 = 8'd200; operand2 = 8'd100; opcode = 4'd0; sel1 = 1'b1;
        tick();
        n_tests++;
        if (result2 !== 8'd44 || carry_flag !== 1'b1 || zero_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL add_carry actual=%0d c=%b z=%b expected=44 c=1 z=0", result2, carry_flag, zero_flag);
        end
        operand1 = 8'd5; operand2 = 8'd5; opcode = 4'd1;
        tick();
        n_tests++;
        if (result2 !== 8'd0 || carry_flag !== 1'b0 || zero_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_zero actual=%0d c=%b z=%b expected=0 c=0 z=1", result2, carry_flag, zero_flag);
        end
        operand1 = 8'd3; operand2 = 8'd9; opcode = 4'd1;
        tick();
        n_tests++;
        if (result2 !== 8'd250 || carry_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_borrow actual=%0d c=%b expected=250 c=1", result2, carry_flag);
        end
    endtask

    task automatic test_store_wrap();
        opcode = 4'hF; sel1 = 1'b0;
        operand1 = 8'd30; offset = 8'd5; sel3 = 1'b1; operand2 = 8'hAB; w_r = 1'b1;
        #1;
        n_tests++;
        if (mem_addr !== 5'd3) begin
            n_fail++; $display("FAIL ea_wrap actual=%0d expected=3", mem_addr);
        end
        tick();
        w_r = 1'b0; operand2 = 8'h00;
        tick();
        n_tests++;
        if (result2 !== 8'hAB) begin
            n_fail++; $display("FAIL store_load actual=%h expected=ab", result2);
        end
        sel3 = 1'b0; operand1 = 8'd30;
        tick();
        n_tests++;
        if (result2 !== 8'd30) begin
            n_fail++; $display("FAIL store_neighbor30 actual=%0d expected=30", result2);
        end
        operand1 = 8'd4;
        tick();
        n_tests++;
        if (result2 !== 8'd4) begin
            n_fail++; $display("FAIL store_neighbor4 actual=%0d expected=4", result2);
        end
    endtask

    task automatic test_read_before_write();
        operand1 = 8'd7; sel3 = 1'b0; sel1 = 1'b0; operand2 = 8'd55; w_r = 1'b1;
        tick();
        n_tests++;
        if (result2 !== 8'd7) begin
            n_fail++; $display("FAIL rbw_old actual=%0d expected=7", result2);
        end
        w_r = 1'b0;
        tick();
        n_tests++;
        if (result2 !== 8'd55) begin
            n_fail++; $display("FAIL rbw_new actual=%0d expected=55", result2);
        end
    endtask

    task automatic test_idle_hold();
        operand1 = 8'h3F; operand2 = 8'h0F; opcode = 4'd2; sel1 = 1'b1;
        tick();
        n_tests++;
        if (result2 !== 8'h0F) begin
            n_fail++; $display("FAIL and_result actual=%h expected=0f", result2);
        end
        opcode = 4'hF;
        for (int k = 0; k < 3; k++) begin
            operand1 = 8'($urandom); operand2 = 8'($urandom);
            tick();
            n_tests++;
            if (result2 !== 8'h0F || zero_flag !== 1'b0 || carry_flag !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_hold cycle=%0d actual=%h z=%b c=%b expected=0f z=0 c=0", k, result2, zero_flag, carry_flag);
            end
        end
        operand1 = 8'd250; operand2 = 8'd10; opcode = 4'd0;
        tick();
        opcode = 4'hF; operand1 = 8'd1; operand2 = 8'd1;
        tick();
        n_tests++;
        if (result2 !== 8'd4 || carry_flag !== 1'b1 || zero_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold_carry actual=%0d c=%b z=%b expected=4 c=1 z=0", result2, carry_flag, zero_flag);
        end
        operand1 = 8'd1; operand2 = 8'd3; opcode = 4'd6;
        tick();
        n_tests++;
        if (result2 !== 8'd8) begin
            n_fail++; $display("FAIL shl actual=%0d expected=8", result2);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            operand1 = 8'($urandom);
            operand2 = 8'($urandom);
            offset   = 8'($urandom);
            opcode   = 4'($urandom_range(0, 15));
            sel1     = 1'($urandom);
            sel3     = 1'($urandom);
            w_r      = ($urandom_range(0, 3) == 0);
            #1;
            n_tests++;
            if (mem_addr !== 5'(model_ea())) begin
                n_fail++; $display("FAIL rand_ea cycle=%0d actual=%0d expected=%0d", k, mem_addr, model_ea());
            end
            tick();
            n_tests++;
            if (result2 !== model_r2() || zero_flag !== 1'(m_zero) || carry_flag !== 1'(m_carry)) begin
                n_fail++;
                $display("FAIL rand_out cycle=%0d actual=%h z=%b c=%b expected=%h z=%0d c=%0d",
                         k, result2, zero_flag, carry_flag, model_r2(), m_zero, m_carry);
            end
        end
        w_r = 1'b0;
        opcode = 4'hF;
    endtask

    task automatic test_async_reset();
        operand1 = 8'd1; operand2 = 8'd2; opcode = 4'd0; sel1 = 1'b1; sel3 = 1'b0; w_r = 1'b0;
        tick();
        operand1 = 8'd9; operand2 = 8'h5A; opcode = 4'hF; w_r = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (result2 !== 8'h00 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_out actual=%h z=%b c=%b expected=00 z=1 c=0", result2, zero_flag, carry_flag);
        end
        sel1 = 1'b0; #1;
        n_tests++;
        if (result2 !== 8'h00) begin
            n_fail++; $display("FAIL async_reset_rdata actual=%h expected=00", result2);
        end
        @(posedge clk); #1;
        w_r = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int a = 0; a < 32; a++) begin
            operand1 = 8'(a);
            tick();
            n_tests++;
            if (result2 !== 8'(a)) begin
                n_fail++; $display("FAIL reinit_read addr=%0d actual=%h expected=%h", a, result2, 8'(a));
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_init_read();
        test_add_sub();
        test_store_wrap();
        test_read_before_write();
        test_idle_hold();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_exec_mem_stage
`default_nettype wire
